// File: rtl/addsub_seq_ctrl.sv
// Byte-serial multi-precision add/subtract sequencer built around one shared
// 8-bit ripple adder; operands arrive and results leave over valid/ready.

module adder8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       c_in,
  output logic [7:0] S,
  output logic       c_out
);
  logic [8:0] w_c;

  always_comb begin
    w_c    = '0;
    S      = '0;
    w_c[0] = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      S[i]     = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    c_out = w_c[8];
  end
endmodule

module addsub_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               sub,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               c_out,
  output logic               ovf,
  output logic               zero,
  output logic               busy
);
  localparam int          W    = 8 * WORDS;
  localparam int unsigned IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_c_out;
  logic          r_ovf;
  logic          r_zero;

  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_s;
  logic          w_co;
  logic [W-1:0]  w_sum_next;

  // Byte lane select for the shared adder, and the sum with the current
  // byte merged in so zero can be judged on the fully assembled result.
  always_comb begin
    w_a_byte   = '0;
    w_b_byte   = '0;
    w_sum_next = r_sum;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_byte             = r_a[i*8 +: 8];
        w_b_byte             = r_b[i*8 +: 8];
        w_sum_next[i*8 +: 8] = w_s;
      end
    end
  end

  adder8 u_adder8 (
    .A     (w_a_byte),
    .B     (w_b_byte),
    .c_in  (r_carry),
    .S     (w_s),
    .c_out (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_co;
          if (r_idx == LAST) begin
            r_idx       <= '0;
            r_c_out     <= w_co;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_s[7] != r_a[W-1]);
            r_zero      <= (w_sum_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl: a 4-byte and a 1-byte instance.

module tb_addsub_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [31:0] op_a4 = '0, op_b4 = '0;
  logic        in_ready4, out_valid4, c_out4, ovf4, zero4, busy4;
  logic [31:0] sum4;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [7:0]  op_a1 = '0, op_b1 = '0;
  logic        in_ready1, out_valid1, c_out1, ovf1, zero1, busy1;
  logic [7:0]  sum1;

  addsub_seq_ctrl #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .sub(sub4), .c_in(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .c_out(c_out4), .ovf(ovf4), .zero(zero4), .busy(busy4)
  );

  addsub_seq_ctrl #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .sub(sub1), .c_in(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
    .c_out(c_out1), .ovf(ovf1), .zero(zero1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, input logic [31:0] esum,
                        input logic ec, input logic eo, input logic ez);
    int   lat;
    logic rdy_low;
    @(negedge clk);
    check({tag, "_rdy0"}, {31'b0, in_ready4}, 32'd1);
    op_a4 = a; op_b4 = b; sub4 = s; cin4 = ci; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    op_a4 = $urandom; op_b4 = $urandom; sub4 = ~s; cin4 = ~ci;
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid4 && lat < 20) begin
      rdy_low &= !in_ready4;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_rdylow"}, {31'b0, rdy_low}, 32'd1);
    check({tag, "_sum"}, sum4, esum);
    check({tag, "_cout"}, {31'b0, c_out4}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, ovf4}, {31'b0, eo});
    check({tag, "_zero"}, {31'b0, zero4}, {31'b0, ez});
    check({tag, "_busy"}, {31'b0, busy4}, 32'd1);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "_vdrop"}, {31'b0, out_valid4}, 32'd0);
    check({tag, "_rdy1"}, {31'b0, in_ready4}, 32'd1);
  endtask

  initial begin
    int   cnt;
    logic ok;
    logic [31:0] held;
    int   hits[3];
    int   nh;

    @(negedge clk);
    check("rst_sum", sum4, 32'd0);
    check("rst_flags", {28'b0, out_valid4, busy4, c_out4, ovf4 | zero4}, 32'd0);
    check("rst_rdy", {31'b0, in_ready4}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy_rel", {31'b0, in_ready4}, 32'd1);

    do_op4("add",   32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 0);
    do_op4("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1);
    do_op4("wrapc", 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0, 1);
    do_op4("ovfadd",32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0);
    do_op4("sub57", 32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 0, 0, 0);
    do_op4("sub75", 32'h0000_0007, 32'h0000_0005, 1, 1, 32'h0000_0002, 1, 0, 0);
    do_op4("subovf",32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0);

    // Backpressure with in_valid held high and operands churning.
    @(negedge clk);
    op_a4 = 32'h1234_5678; op_b4 = 32'h1111_1111; sub4 = 0; cin4 = 0; in_valid4 = 1'b1;
    cnt = 0;
    while (!out_valid4 && cnt < 20) begin @(negedge clk); cnt++; end
    check("bp_valid", {31'b0, out_valid4}, 32'd1);
    check("bp_sum", sum4, 32'h2345_6789);
    held = sum4;
    for (int i = 0; i < 5; i++) begin
      op_a4 = $urandom; op_b4 = $urandom; sub4 = $urandom; cin4 = $urandom;
      @(negedge clk);
      check("bp_hold_sum", sum4, held);
      check("bp_hold_st", {28'b0, out_valid4, in_ready4, busy4, c_out4 | ovf4 | zero4}, 32'b1010);
    end
    op_a4 = 32'd3; op_b4 = 32'd4; sub4 = 0; cin4 = 0; out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("bp_rel", {30'b0, out_valid4, in_ready4}, 32'b01);
    @(negedge clk);
    in_valid4 = 1'b0;
    check("bp_acc2", {30'b0, in_ready4, busy4}, 32'b01);
    cnt = 0;
    while (!out_valid4 && cnt < 20) begin @(negedge clk); cnt++; end
    check("bp_sum2", sum4, 32'd7);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;

    // Reset during the second RUN cycle.
    @(negedge clk);
    op_a4 = 32'hFFFF_FFFF; op_b4 = 32'h1; sub4 = 0; cin4 = 0; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    check("rmid_busy", {31'b0, busy4}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_sum", sum4, 32'd0);
    check("rmid_out", {26'b0, out_valid4, busy4, c_out4, ovf4, zero4, in_ready4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid4) ok = 1'b0;
    end
    check("rmid_novalid", {31'b0, ok}, 32'd1);
    do_op4("clean", 32'h1, 32'h1, 0, 0, 32'h2, 0, 0, 0);

    // Single-byte instance.
    @(negedge clk);
    op_a1 = 8'h80; op_b1 = 8'h80; sub1 = 0; cin1 = 0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    cnt = 0;
    while (!out_valid1 && cnt < 20) begin @(negedge clk); cnt++; end
    check("w1_lat", cnt, 32'd1);
    check("w1_res", {20'b0, sum1, c_out1, ovf1, zero1, 1'b0}, {20'b0, 8'h00, 4'b1110});
    out_ready1 = 1'b1;
    @(negedge clk);
    op_a1 = 8'h01; op_b1 = 8'h02; in_valid1 = 1'b1;
    nh = 0;
    hits[0] = 0; hits[1] = 0; hits[2] = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid1 && nh < 3) begin
        hits[nh] = i;
        nh++;
      end
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    check("w1_nres", nh, 32'd3);
    check("w1_gap1", hits[1] - hits[0], 32'd3);
    check("w1_gap2", hits[2] - hits[1], 32'd3);
    check("w1_sum2", {24'b0, sum1}, 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
